// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome, BHT counter
// states and the saturating counter step.
package mips_core_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } BhtCounter;

  function automatic BhtCounter bht_next(
    input BhtCounter    c,
    input BranchOutcome o
  );
    BhtCounter n;
    n = c;
    unique case (1'b1)
      (o == TAKEN && c != STRONG_T):
        n = BhtCounter'(c + 2'd1);
      (o == NOT_TAKEN && c != STRONG_NT):
        n = BhtCounter'(c - 2'd1);
      default: n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mips_core_ifc.sv
// Decode/EX/hazard interfaces used by the
// branch predictor (pc, decoded branch, hazard, result).
interface pc_ifc;
  import mips_core_pkg::*;
  logic [ADDR_WIDTH-1:0] pc;
  modport in  (input pc);
  modport out (output pc);
endinterface

interface branch_decoded_ifc;
  import mips_core_pkg::*;
  logic                  valid;
  logic                  is_jump;
  logic [ADDR_WIDTH-1:0] target;
  BranchOutcome          prediction;
  logic [ADDR_WIDTH-1:0] target_post_predict;
  modport hazard (
    input  valid, is_jump, target,
    output prediction, target_post_predict
  );
  modport decode (
    output valid, is_jump, target,
    input  prediction, target_post_predict
  );
endinterface

interface hazard_control_ifc;
  logic flush;
  logic stall;
  modport in  (input flush, stall);
  modport out (output flush, stall);
endinterface

interface branch_result_ifc;
  import mips_core_pkg::*;
  logic                  valid;
  BranchOutcome          prediction;
  BranchOutcome          outcome;
  logic [ADDR_WIDTH-1:0] target;
  modport in  (input valid, prediction, outcome, target);
  modport out (output valid, prediction, outcome, target);
endinterface

// File: rtl/bp_pending_fifo.sv
// In-order FIFO of pending branch table indices.
// push/pop/clear in; head/full/empty/count and error pulses out.
module bp_pending_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  assign do_pop    = pop && !empty;
  assign underflow = pop && empty;
  // A pop frees the slot, so push into a full FIFO is fine then.
  assign overflow  = push && full && !pop;
  // Clear discards any same-cycle push.
  assign do_push   = push && (!full || pop) && !clear;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor_bimodal.sv
// Bimodal branch predictor: 2-bit counter table, zero-latency
// prediction to decode, in-order training from EX, error flags, stats.
module branch_predictor_bimodal
  import mips_core_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int PEND_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_ifc.in                  dec_pc,
  branch_decoded_ifc.hazard  dec_branch,
  hazard_control_ifc.in      dec_hc,
  branch_result_ifc.in       ex_result,
  output logic               mispredict,
  output logic               overflow_err,
  output logic               underflow_err,
  output logic [31:0]        branch_count,
  output logic [31:0]        mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int CW      = $clog2(PEND_DEPTH) + 1;

  BhtCounter             bht [ENTRIES];
  logic [INDEX_BITS-1:0] idx;
  logic [INDEX_BITS-1:0] head;
  logic                  push;
  logic                  full;
  logic                  empty;
  logic                  ovf;
  logic                  unf;
  logic                  upd;
  logic [CW-1:0]         pend_count;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  BranchOutcome          pred;
  logic [ADDR_WIDTH-1:0] tpp;
  logic                  unused_target;

  assign unused_target = ^{ex_result.target, full};

  assign idx      = dec_pc.pc[INDEX_BITS+1:2];
  assign pc_plus4 = dec_pc.pc + ADDR_WIDTH'(4);

  always_comb begin
    pred = NOT_TAKEN;
    tpp  = pc_plus4;
    unique case (1'b1)
      (dec_branch.valid && dec_branch.is_jump): begin
        pred = TAKEN;
        tpp  = dec_branch.target;
      end
      (dec_branch.valid && !dec_branch.is_jump
        && bht[idx][1]): begin
        pred = TAKEN;
        tpp  = dec_branch.target;
      end
      default: ;
    endcase
  end

  assign dec_branch.prediction          = pred;
  assign dec_branch.target_post_predict = tpp;

  assign push = dec_branch.valid && !dec_branch.is_jump
             && !dec_hc.stall && !dec_hc.flush;

  assign mispredict = ex_result.valid
    && (ex_result.prediction != ex_result.outcome);

  assign upd = ex_result.valid && !empty;

  bp_pending_fifo #(
    .WIDTH (INDEX_BITS),
    .DEPTH (PEND_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (idx),
    .pop       (ex_result.valid),
    .clear     (mispredict),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (pend_count),
    .overflow  (ovf),
    .underflow (unf)
  );

  // Read and update of the same entry in one cycle: no bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        bht[i] <= WEAK_NT;
    end else if (upd) begin
      bht[head] <= bht_next(bht[head], ex_result.outcome);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err     <= 1'b0;
      underflow_err    <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (ovf) overflow_err <= 1'b1;
      if (unf) underflow_err <= 1'b1;
      if (ex_result.valid)
        branch_count <= branch_count + 32'd1;
      if (mispredict)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bimodal.sv
// Scoreboard bench for branch_predictor_bimodal:
// directed vectors, expectations queued, negedge monitor compares.
module tb_branch_predictor_bimodal;
  import mips_core_pkg::*;

  localparam int K_PRED = 0;
  localparam int K_TPP  = 1;
  localparam int K_MISP = 2;
  localparam int K_OVF  = 3;
  localparam int K_UNF  = 4;
  localparam int K_BC   = 5;
  localparam int K_MC   = 6;
  localparam int K_CNT  = 7;
  localparam int K_BHT0 = 8;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        mispredict;
  logic        overflow_err;
  logic        underflow_err;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  pc_ifc             pc_if ();
  branch_decoded_ifc br_if ();
  hazard_control_ifc hc_if ();
  branch_result_ifc  ex_if ();

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  branch_predictor_bimodal dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dec_pc           (pc_if),
    .dec_branch       (br_if),
    .dec_hc           (hc_if),
    .ex_result        (ex_if),
    .mispredict       (mispredict),
    .overflow_err     (overflow_err),
    .underflow_err    (underflow_err),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] actual(input int k);
    logic [31:0] a;
    a = 32'hdead_beef;
    case (k)
      K_PRED: a = {31'd0, br_if.prediction};
      K_TPP:  a = br_if.target_post_predict;
      K_MISP: a = {31'd0, mispredict};
      K_OVF:  a = {31'd0, overflow_err};
      K_UNF:  a = {31'd0, underflow_err};
      K_BC:   a = branch_count;
      K_MC:   a = mispredict_count;
      K_CNT:  a = 32'(dut.pend_count);
      K_BHT0: a = {30'd0, dut.bht[0]};
      default: a = 32'hdead_beef;
    endcase
    return a;
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.kind);
      checks++;
      if (a !== e.val) begin
        failures++;
        $display("FAIL %s: got %0h want %0h",
                 e.name, a, e.val);
      end
    end
  end

  task automatic ex(input int k, input logic [31:0] v,
                    input string n);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic j,
                     input logic [31:0] pc,
                     input logic [31:0] tgt);
    br_if.valid   = v;
    br_if.is_jump = j;
    pc_if.pc      = pc;
    br_if.target  = tgt;
  endtask

  task automatic res(input logic v, input BranchOutcome p,
                     input BranchOutcome o);
    ex_if.valid      = v;
    ex_if.prediction = p;
    ex_if.outcome    = o;
  endtask

  initial begin
    rst_n        = 1'b0;
    hc_if.stall  = 1'b0;
    hc_if.flush  = 1'b0;
    ex_if.target = 32'h0;
    dec(1'b0, 1'b0, 32'h0, 32'h0);
    res(1'b0, NOT_TAKEN, NOT_TAKEN);
    step();
    ex(K_PRED, 0, "rst_pred");
    ex(K_TPP, 32'h4, "rst_tpp");
    ex(K_BC, 0, "rst_bc");
    ex(K_MC, 0, "rst_mc");
    ex(K_OVF, 0, "rst_ovf");
    ex(K_UNF, 0, "rst_unf");
    ex(K_CNT, 0, "rst_cnt");
    ex(K_BHT0, 1, "rst_bht0");
    step();
    rst_n = 1'b1;
    step();

    dec(1'b1, 1'b0, 32'h100, 32'h140);
    ex(K_PRED, 0, "a_pred");
    ex(K_TPP, 32'h104, "a_tpp");
    step();

    dec(1'b0, 1'b0, 32'h100, 32'h140);
    res(1'b1, NOT_TAKEN, TAKEN);
    ex(K_CNT, 1, "b_cnt");
    ex(K_MISP, 1, "b_misp");
    step();

    res(1'b0, NOT_TAKEN, NOT_TAKEN);
    ex(K_BHT0, 2, "c_bht0");
    ex(K_CNT, 0, "c_cnt");
    ex(K_MC, 1, "c_mc");
    ex(K_BC, 1, "c_bc");
    ex(K_MISP, 0, "c_misp");
    dec(1'b1, 1'b0, 32'h100, 32'h140);
    ex(K_PRED, 1, "c_pred");
    ex(K_TPP, 32'h140, "c_tpp");
    step();

    for (int i = 0; i < 4; i++) begin
      dec(1'b0, 1'b0, 32'h100, 32'h140);
      res(1'b1, TAKEN, TAKEN);
      ex(K_MISP, 0, "sat_misp");
      ex(K_CNT, 1, "sat_cnt1");
      step();
      res(1'b0, NOT_TAKEN, NOT_TAKEN);
      ex(K_BHT0, 3, "sat_bht0");
      ex(K_CNT, 0, "sat_cnt0");
      dec(1'b1, 1'b0, 32'h100, 32'h140);
      ex(K_PRED, 1, "sat_pred");
      step();
    end

    dec(1'b0, 1'b0, 32'h100, 32'h140);
    res(1'b1, TAKEN, NOT_TAKEN);
    ex(K_MISP, 1, "d_misp");
    ex(K_BC, 5, "d_bc");
    step();

    res(1'b0, NOT_TAKEN, NOT_TAKEN);
    ex(K_BHT0, 2, "e_bht0");
    ex(K_MC, 2, "e_mc");
    ex(K_BC, 6, "e_bc");
    ex(K_CNT, 0, "e_cnt");
    dec(1'b1, 1'b1, 32'h180, 32'h200);
    ex(K_PRED, 1, "jmp_pred");
    ex(K_TPP, 32'h200, "jmp_tpp");
    step();

    ex(K_CNT, 0, "jmp_cnt");
    ex(K_BHT0, 2, "jmp_bht0");
    dec(1'b1, 1'b0, 32'h100, 32'h140);
    hc_if.stall = 1'b1;
    ex(K_PRED, 1, "f_pred");
    step();

    hc_if.stall = 1'b0;
    hc_if.flush = 1'b1;
    ex(K_CNT, 0, "stall_cnt");
    step();

    hc_if.flush = 1'b0;
    ex(K_CNT, 0, "flush_cnt");
    for (int k = 0; k < 4; k++) begin
      dec(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h140);
      step();
    end

    dec(1'b1, 1'b0, 32'h110, 32'h140);
    ex(K_CNT, 4, "full_cnt");
    ex(K_OVF, 0, "full_ovf");
    step();

    ex(K_OVF, 1, "ovf_set");
    ex(K_CNT, 4, "ovf_cnt");
    dec(1'b1, 1'b0, 32'h114, 32'h140);
    res(1'b1, NOT_TAKEN, NOT_TAKEN);
    ex(K_MISP, 0, "pp_misp");
    step();

    dec(1'b0, 1'b0, 32'h0, 32'h0);
    res(1'b0, NOT_TAKEN, NOT_TAKEN);
    ex(K_CNT, 4, "pp_cnt");
    ex(K_BHT0, 1, "pp_bht0");
    ex(K_BC, 7, "pp_bc");
    ex(K_MC, 2, "pp_mc");
    ex(K_OVF, 1, "pp_ovf");
    res(1'b1, TAKEN, NOT_TAKEN);
    ex(K_MISP, 1, "k_misp");
    step();

    res(1'b0, NOT_TAKEN, NOT_TAKEN);
    ex(K_CNT, 0, "clr_cnt");
    ex(K_MC, 3, "clr_mc");
    ex(K_BC, 8, "clr_bc");
    ex(K_BHT0, 1, "clr_bht0");
    res(1'b1, NOT_TAKEN, NOT_TAKEN);
    ex(K_MISP, 0, "l_misp");
    ex(K_UNF, 0, "l_unf");
    step();

    res(1'b0, NOT_TAKEN, NOT_TAKEN);
    ex(K_UNF, 1, "unf_set");
    ex(K_BC, 9, "unf_bc");
    ex(K_BHT0, 1, "unf_bht0");
    ex(K_CNT, 0, "unf_cnt");
    ex(K_MC, 3, "unf_mc");
    dec(1'b1, 1'b0, 32'h100, 32'h140);
    step();

    dec(1'b0, 1'b0, 32'h0, 32'h0);
    ex(K_CNT, 1, "n_cnt");
    step();

    rst_n = 1'b0;
    ex(K_CNT, 0, "mr_cnt");
    ex(K_BC, 0, "mr_bc");
    ex(K_MC, 0, "mr_mc");
    ex(K_OVF, 0, "mr_ovf");
    ex(K_UNF, 0, "mr_unf");
    ex(K_BHT0, 1, "mr_bht0");
    step();
    rst_n = 1'b1;
    step();
    step();

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
